muldiv_issue: RTL and testbench

MULDIV_ISSUE -- requirements
Module: muldiv_issue

---
 rtl/muldiv_issue.sv | 122 ++++++++++++
 tb/tb_muldiv_issue.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_issue.sv
// rtl/muldiv_issue.sv - single-outstanding issue/response sequencer for an external multiply/divide unit
module muldiv_issue #(
  parameter int TAG_W   = 5,
  parameter int MAX_LAT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [31:0]      req_num1_i,
  input  logic [31:0]      req_num2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             mdu_valid_o,
  output logic [2:0]       mdu_op_o,
  output logic [31:0]      mdu_num1_o,
  output logic [31:0]      mdu_num2_o,
  input  logic             mdu_busy_i,
  input  logic [31:0]      mdu_result_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             err_o
);

  // Counter is at least 8 bits and always wide enough to hold MAX_LAT.
  localparam int CNT_W = ($clog2(MAX_LAT + 1) > 8) ? $clog2(MAX_LAT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [31:0]      num1_q;
  logic [31:0]      num2_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             expired;

  // The current WAIT/DRAIN cycle is the MAX_LAT-th one and the unit is still busy.
  assign expired = mdu_busy_i && (cnt_q >= CNT_LAST);

  // Ready is gated by reset so nothing can be taken while the block is held in reset.
  assign req_ready_o  = rst_i && (state_q == S_IDLE) && !flush_i;
  assign mdu_valid_o  = (state_q == S_LAUNCH) && !flush_i;
  assign mdu_op_o     = op_q;
  assign mdu_num1_o   = num1_q;
  assign mdu_num2_o   = num2_q;
  assign rsp_valid_o  = (state_q == S_RESP);
  assign rsp_result_o = result_q;
  assign rsp_tag_o    = tag_q;
  assign err_o        = err_q;

  // Request sequencer: operands stay registered (and visible to the unit) until the next accept.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      num1_q   <= 32'd0;
      num2_q   <= 32'd0;
      tag_q    <= '0;
      result_q <= 32'd0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && !flush_i) begin
            op_q    <= req_op_i;
            num1_q  <= req_num1_i;
            num2_q  <= req_num2_i;
            tag_q   <= req_tag_i;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= flush_i ? S_IDLE : S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (flush_i) begin
            state_q <= S_DRAIN;
          end else if (!mdu_busy_i) begin
            result_q <= mdu_result_i;
            state_q  <= S_RESP;
          end else if (expired) begin
            err_q    <= 1'b1;
            result_q <= 32'd0;
            state_q  <= S_RESP;
          end
        end
        S_DRAIN: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (!mdu_busy_i) begin
            state_q <= S_IDLE;
          end else if (expired) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_RESP: begin
          if (flush_i || rsp_ready_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_issue.sv
// tb/tb_muldiv_issue.sv - self-checking bench for muldiv_issue with a behavioural muldiv unit
module tb_muldiv_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_num1;
  logic [31:0] req_num2;
  logic [4:0]  req_tag;
  logic        mdu_valid;
  logic [2:0]  mdu_op;
  logic [31:0] mdu_num1;
  logic [31:0] mdu_num2;
  logic        mdu_busy;
  logic [31:0] mdu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_tag;
  logic        err;

  logic        wd_req_valid;
  logic        wd_req_ready;
  logic        wd_mdu_valid;
  logic [2:0]  wd_mdu_op;
  logic [31:0] wd_mdu_num1;
  logic [31:0] wd_mdu_num2;
  logic        wd_rsp_valid;
  logic        wd_rsp_ready;
  logic [31:0] wd_rsp_result;
  logic [4:0]  wd_rsp_tag;
  logic        wd_err;

  always #5 clk = ~clk;

  muldiv_issue #(.TAG_W(5), .MAX_LAT(64)) dut (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_num1_i(req_num1), .req_num2_i(req_num2), .req_tag_i(req_tag),
    .mdu_valid_o(mdu_valid), .mdu_op_o(mdu_op), .mdu_num1_o(mdu_num1), .mdu_num2_o(mdu_num2),
    .mdu_busy_i(mdu_busy), .mdu_result_i(mdu_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .rsp_tag_o(rsp_tag), .err_o(err)
  );

  muldiv_issue #(.TAG_W(5), .MAX_LAT(16)) wd (
    .clk_i(clk), .rst_i(rst_n), .flush_i(1'b0),
    .req_valid_i(wd_req_valid), .req_ready_o(wd_req_ready), .req_op_i(req_op),
    .req_num1_i(req_num1), .req_num2_i(req_num2), .req_tag_i(req_tag),
    .mdu_valid_o(wd_mdu_valid), .mdu_op_o(wd_mdu_op), .mdu_num1_o(wd_mdu_num1), .mdu_num2_o(wd_mdu_num2),
    .mdu_busy_i(1'b1), .mdu_result_i(32'hDEADBEEF),
    .rsp_valid_o(wd_rsp_valid), .rsp_ready_i(wd_rsp_ready), .rsp_result_o(wd_rsp_result),
    .rsp_tag_o(wd_rsp_tag), .err_o(wd_err)
  );

  // Behavioural unit: result computed from the live operand outputs.
  function automatic logic [31:0] unit_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    r = 32'd0;
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else r = $signed(a) / $signed(b);
      end
      3'd5: r = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  logic [4:0] ucnt;
  int         pulse_cnt = 0;
  assign mdu_busy   = (ucnt != 5'd0);
  assign mdu_result = unit_calc(mdu_op, mdu_num1, mdu_num2);

  // Unit busy: 4 cycles for multiplies, 17 for divides, starting the cycle after the start pulse.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ucnt <= 5'd0;
    else if (mdu_valid) ucnt <= mdu_op[2] ? 5'd17 : 5'd4;
    else if (ucnt != 5'd0) ucnt <= ucnt - 5'd1;
  end

  // Count start pulses seen by the unit.
  always @(posedge clk) begin
    if (mdu_valid) pulse_cnt <= pulse_cnt + 1;
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  vec_t        vecs [10];
  exp_t        sb [$];
  int          passed = 0;
  int          total = 0;
  logic [2:0]  cur_op;
  logic [31:0] cur_a;
  logic [31:0] cur_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge (LAUNCH cycle).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] res, input bit push, output int tries);
    exp_t e;
    req_op = op; req_num1 = a; req_num2 = b; req_tag = tag; req_valid = 1'b1;
    cur_op = op; cur_a = a; cur_b = b;
    tries = 0;
    #1;
    while (!req_ready && tries < 50) begin
      @(negedge clk); #1; tries++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (push) begin
      e.res = res; e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // k counts falling edges from the accept edge: k=1 is the LAUNCH cycle.
  task automatic wait_rsp(input int exp_lat, input string name);
    int   k;
    bit   hold_ok;
    bit   ready_low;
    exp_t e;
    k = 1; hold_ok = 1'b1; ready_low = 1'b1;
    while (!rsp_valid && k < 100) begin
      if (mdu_op !== cur_op || mdu_num1 !== cur_a || mdu_num2 !== cur_b) hold_ok = 1'b0;
      if (req_ready) ready_low = 1'b0;
      @(negedge clk); k++;
    end
    if (!rsp_valid) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (exp_lat > 0) chk({name, "_lat"}, k, exp_lat);
    chk({name, "_hold"}, hold_ok, 1);
    chk({name, "_ready_low"}, ready_low, 1);
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({name, "_result"}, rsp_result, e.res);
      chk({name, "_tag"}, rsp_tag, e.tag);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({name, "_rsp_done"}, rsp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int tries;
    int k;
    int p0;
    int exit_k;
    bit stable;
    bit no_rsp;

    vecs[0] = '{3'd0, 32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 7};
    vecs[1] = '{3'd1, 32'h80000000,   32'h80000000, 5'd1,  32'h40000000, 7};
    vecs[2] = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd2,  32'hFFFFFFFF, 7};
    vecs[3] = '{3'd3, 32'hFFFFFFFF,   32'd2,        5'd3,  32'h00000001, 7};
    vecs[4] = '{3'd4, 32'd100,        32'd0,        5'd4,  32'hFFFFFFFF, 20};
    vecs[5] = '{3'd4, 32'hFFFFFFEC,   32'd3,        5'd6,  32'hFFFFFFFA, 20};
    vecs[6] = '{3'd5, 32'd100,        32'd7,        5'd7,  32'h0000000E, 20};
    vecs[7] = '{3'd6, 32'hFFFFFFEC,   32'd3,        5'd8,  32'hFFFFFFFE, 20};
    vecs[8] = '{3'd7, 32'd100,        32'd7,        5'd10, 32'h00000002, 20};
    vecs[9] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 5'd31, 32'h80000000, 20};

    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b1; rsp_ready = 1'b1;
    wd_req_valid = 1'b0; wd_rsp_ready = 1'b0;
    req_op = 3'd0; req_num1 = 32'd0; req_num2 = 32'd0; req_tag = 5'd0;
    cur_op = 3'd0; cur_a = 32'd0; cur_b = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mdu_valid", mdu_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_mdu_num1", mdu_num1, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", req_ready, 1);
    @(negedge clk);

    // Table-driven requests
    p0 = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].res, 1'b1, tries);
      wait_rsp(vecs[i].lat, $sformatf("vec%0d", i));
    end
    chk("one_pulse_each", pulse_cnt - p0, 10);

    // Response back-pressure for 10 cycles
    rsp_ready = 1'b0;
    issue(3'd0, 32'd3, 32'd4, 5'd9, 32'd12, 1'b1, tries);
    k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!rsp_valid || rsp_result !== 32'd12 || rsp_tag !== 5'd9 || req_ready) stable = 1'b0;
      @(negedge clk);
    end
    chk("bp_stable", stable, 1);
    wait_rsp(0, "bp");

    // Flush during LAUNCH suppresses the start pulse
    p0 = pulse_cnt;
    issue(3'd5, 32'd9, 32'd3, 5'd1, 32'd0, 1'b0, tries);
    flush = 1'b1;
    #1;
    chk("flush_launch_mdu_valid", mdu_valid, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_launch_idle", req_ready, 1);
    chk("flush_launch_no_pulse", pulse_cnt - p0, 0);
    @(negedge clk);

    // Flush together with a request in IDLE accepts nothing
    req_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_idle_ready", req_ready, 0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1;
    chk("flush_idle_still_idle", req_ready, 1);
    chk("flush_idle_no_launch", mdu_valid, 0);
    @(negedge clk);

    // Flush in third WAIT cycle of DIVU, then DRAIN until the unit goes idle
    issue(3'd5, 32'd50, 32'd5, 5'd3, 32'd0, 1'b0, tries);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("drain_flush_ready", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    k = 5; exit_k = 0; no_rsp = 1'b1;
    for (int i = 0; i < 40 && exit_k == 0; i++) begin
      flush = (k == 8);
      #1;
      if (rsp_valid) no_rsp = 1'b0;
      if (req_ready) exit_k = k;
      @(negedge clk); k++;
    end
    flush = 1'b0;
    chk("drain_exit_cycle", exit_k, 20);
    chk("drain_no_rsp", no_rsp, 1);
    issue(3'd7, 32'd100, 32'd7, 5'd11, 32'd2, 1'b1, tries);
    wait_rsp(20, "after_drain");

    // Flush in RESP drops the response
    rsp_ready = 1'b0;
    issue(3'd0, 32'd5, 32'd5, 5'd2, 32'd25, 1'b0, tries);
    k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    chk("flush_resp_seen", rsp_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_resp_drop", rsp_valid, 0);
    chk("flush_resp_idle", req_ready, 1);
    rsp_ready = 1'b1;
    @(negedge clk);

    // Reset in WAIT abandons the request; accept right after release
    issue(3'd4, 32'd9, 32'd3, 5'd6, 32'd0, 1'b0, tries);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_wait_rsp_valid", rsp_valid, 0);
    chk("rst_wait_mdu_op", mdu_op, 0);
    chk("rst_wait_mdu_num1", mdu_num1, 0);
    chk("rst_wait_mdu_num2", mdu_num2, 0);
    chk("rst_wait_req_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd3, 32'hFFFFFFFF, 32'd2, 5'd12, 32'h00000001, 1'b1, tries);
    chk("rst_first_accept", tries, 0);
    wait_rsp(7, "mulhu_after_rst");

    // Watchdog on the MAX_LAT=16 instance with the unit stuck busy
    req_op = 3'd4; req_num1 = 32'd1; req_num2 = 32'd1; req_tag = 5'd7;
    wd_req_valid = 1'b1;
    #1;
    chk("wd_ready", wd_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    wd_req_valid = 1'b0;
    k = 1;
    while (!wd_err && k < 60) begin @(negedge clk); k++; end
    chk("wd_err_cycle", k, 18);
    chk("wd_rsp_valid", wd_rsp_valid, 1);
    chk("wd_result", wd_rsp_result, 0);
    chk("wd_tag", wd_rsp_tag, 7);
    wd_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wd_rsp_ready = 1'b0;
    chk("wd_rsp_done", wd_rsp_valid, 0);
    repeat (5) @(negedge clk);
    chk("wd_err_sticky", wd_err, 1);
    chk("wd_idle", wd_req_ready, 1);
    chk("main_err_clear", err, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("wd_err_reset", wd_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
